// File: rtl/player_io_pkg.sv
// Shared constants for the player I/O register window: bus widths,
// register offsets relative to IO_BASE and the internal counter width.
package player_io_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 18;
  localparam int CNT_W  = 8;

  localparam logic [ADDR_W-1:0] OFS_SHOT_EVT = 14'd0;
  localparam logic [ADDR_W-1:0] OFS_HIT_EVT  = 14'd1;
  localparam logic [ADDR_W-1:0] OFS_ENABLE   = 14'd2;
  localparam logic [ADDR_W-1:0] OFS_LEVEL    = 14'd3;
  localparam logic [ADDR_W-1:0] OFS_HITCNT   = 14'd4;

endpackage

// File: rtl/player_io_chan.sv
// One raw input path: 2-flop synchroniser, debouncer, rising-edge detect
// and a fixed-width pulse timer gated by the channel enable.
module player_io_chan
  import player_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic en,
  output logic evt,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);

  logic [1:0]       sync_q;
  logic [1:0]       sync_vld;
  logic             armed;
  logic             db;
  logic             db_d;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic             sample;
  logic             rise;

  assign sample = sync_q[1];
  assign rise   = db & ~db_d;

  // Until a genuine low period has been debounced after reset, the path is
  // not armed: an input already held high must not look like a new press.
  // NOTE: every register here uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      sync_vld <= '0;
      armed    <= 1'b0;
      db       <= 1'b0;
      db_d     <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw};
      sync_vld <= {sync_vld[0], 1'b1};
      db_d     <= db;
      if (!armed) begin
        if (!sync_vld[1] || sample) begin
          db_cnt <= '0;
        end else if (db_cnt == DEB_LAST) begin
          armed  <= 1'b1;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else if (sample != db) begin
        if (db_cnt == DEB_LAST) begin
          db     <= sample;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // A rise while the timer runs is ignored so the pulse is never stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
    end else if (!en) begin
      pulse_cnt <= '0;
    end else if (rise && (pulse_cnt == '0)) begin
      pulse_cnt <= PULSE_LOAD;
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - CNT_W'(1);
    end
  end

  assign evt   = rise & en;
  assign level = db;
  assign pulse = |pulse_cnt;

endmodule

// File: rtl/player_io_map.sv
// Player trigger/hit-sensor block with a small CPU register window.
// Optional per-channel saturating hit counters: define PLAYER_IO_HIT_COUNT_EN.
module player_io_map
  import player_io_pkg::*;
#(
  parameter int                NUM_PLAYERS       = 2,
  parameter logic [ADDR_W-1:0] IO_BASE           = 14'd254,
  parameter int                DEBOUNCE_CYCLES   = 4,
  parameter int                SHOT_PULSE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   CLR,
  input  logic [NUM_PLAYERS-1:0] trigger,
  input  logic [NUM_PLAYERS-1:0] sens,
  output logic [NUM_PLAYERS-1:0] shot,
  output logic [NUM_PLAYERS-1:0] hit,
  input  logic                   wr,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout
);

  logic [NUM_PLAYERS-1:0] trig_evt;
  logic [NUM_PLAYERS-1:0] sens_evt;
  logic [NUM_PLAYERS-1:0] trig_lvl;
  logic [NUM_PLAYERS-1:0] sens_lvl;
  logic [NUM_PLAYERS-1:0] shot_evt;
  logic [NUM_PLAYERS-1:0] hit_evt;
  logic [NUM_PLAYERS-1:0] enable;
  logic [ADDR_W-1:0]      ofs;
  logic [DATA_W-1:0]      rd_data;
  logic                   sel_shot;
  logic                   sel_hit;
  logic                   sel_enable;
  logic                   sel_level;
  logic                   unused_din;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_chan
    player_io_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PULSE_CYCLES   (SHOT_PULSE_CYCLES)
    ) u_trig (
      .clk  (clk),
      .rst_n(CLR),
      .raw  (trigger[i]),
      .en   (enable[i]),
      .evt  (trig_evt[i]),
      .level(trig_lvl[i]),
      .pulse(shot[i])
    );

    player_io_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PULSE_CYCLES   (SHOT_PULSE_CYCLES)
    ) u_sens (
      .clk  (clk),
      .rst_n(CLR),
      .raw  (sens[i]),
      .en   (enable[i]),
      .evt  (sens_evt[i]),
      .level(sens_lvl[i]),
      .pulse(hit[i])
    );
  end

  // Addresses below IO_BASE wrap to large offsets and fall outside the window.
  assign ofs        = addr - IO_BASE;
  assign sel_shot   = (ofs == OFS_SHOT_EVT);
  assign sel_hit    = (ofs == OFS_HIT_EVT);
  assign sel_enable = (ofs == OFS_ENABLE);
  assign sel_level  = (ofs == OFS_LEVEL);
  assign unused_din = ^din[DATA_W-1:NUM_PLAYERS];

`ifdef PLAYER_IO_HIT_COUNT_EN
  logic [CNT_W-1:0]       hit_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] sel_cnt;

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      sel_cnt[i] = (ofs == (OFS_HITCNT + ADDR_W'(i)));
    end
  end

  // NOTE: this array is a handful of flops, not a RAM, so it takes the reset.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < NUM_PLAYERS; i++) hit_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (wr && sel_cnt[i]) begin
          hit_cnt[i] <= '0;
        end else if (sens_evt[i] && (hit_cnt[i] != '1)) begin
          hit_cnt[i] <= hit_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`endif

  // NOTE: rd_data is defaulted first so no path through this block infers a latch.
  always_comb begin
    rd_data = '0;
    if (sel_shot) begin
      rd_data[NUM_PLAYERS-1:0] = shot_evt;
    end else if (sel_hit) begin
      rd_data[NUM_PLAYERS-1:0] = hit_evt;
    end else if (sel_enable) begin
      rd_data[NUM_PLAYERS-1:0] = enable;
    end else if (sel_level) begin
      rd_data[2*NUM_PLAYERS-1:0] = {sens_lvl, trig_lvl};
    end
`ifdef PLAYER_IO_HIT_COUNT_EN
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (sel_cnt[i]) rd_data[CNT_W-1:0] = hit_cnt[i];
    end
`endif
  end

  // A read-clear drops every returned bit, but a same-cycle event still sets.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      dout     <= '0;
      shot_evt <= '0;
      hit_evt  <= '0;
      enable   <= '1;
    end else begin
      dout     <= rd_data;
      shot_evt <= (sel_shot && !wr) ? trig_evt : (shot_evt | trig_evt);
      hit_evt  <= (sel_hit  && !wr) ? sens_evt : (hit_evt  | sens_evt);
      if (wr && sel_enable) enable <= din[NUM_PLAYERS-1:0];
    end
  end

endmodule

// File: tb/tb_player_io_map.sv
// Self-checking bench for player_io_map: directed scenarios plus randomized
// input waveforms compared against a segment-level behavioural model.
module tb_player_io_map;

  localparam int          N    = 2;
  localparam int          DEB  = 4;
  localparam int          PW   = 8;
  localparam logic [13:0] BASE = 14'd254;
  localparam logic [13:0] IDLE = 14'd0;
  localparam int          RLEN = 200;
  localparam int          RT   = RLEN + 40;

  logic         clk = 1'b0;
  logic         CLR;
  logic [N-1:0] trigger;
  logic [N-1:0] sens;
  logic [N-1:0] shot;
  logic [N-1:0] hit;
  logic         wr;
  logic [13:0]  addr;
  logic [17:0]  din;
  logic [17:0]  dout;

  int checks = 0;
  int errors = 0;

  player_io_map #(
    .NUM_PLAYERS      (N),
    .IO_BASE          (BASE),
    .DEBOUNCE_CYCLES  (DEB),
    .SHOT_PULSE_CYCLES(PW)
  ) dut (
    .clk    (clk),
    .CLR    (CLR),
    .trigger(trigger),
    .sens   (sens),
    .shot   (shot),
    .hit    (hit),
    .wr     (wr),
    .addr   (addr),
    .din    (din),
    .dout   (dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [17:0] d);
    tick();
    addr = a;
    wr   = 1'b0;
    tick();
    d    = dout;
    addr = IDLE;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [17:0] d);
    tick();
    addr = a;
    din  = d;
    wr   = 1'b1;
    tick();
    wr   = 1'b0;
    addr = IDLE;
    din  = '0;
  endtask

  task automatic test_reset();
    logic [17:0] rd;
    CLR = 1'b0; trigger = '0; sens = '0; wr = 1'b0; addr = IDLE; din = '0;
    #23;
    checks++;
    if ({shot, hit, dout} !== 22'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {shot, hit, dout});
    end
    @(negedge clk);
    CLR = 1'b1;
    idle(12);
    bus_read(BASE + 14'd2, rd);
    checks++;
    if (rd !== 18'h3) begin errors++; $display("FAIL reset_enable got %h want 3", rd); end
    bus_read(BASE, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL reset_shot_evt got %h want 0", rd); end
    bus_read(BASE + 14'd1, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL reset_hit_evt got %h want 0", rd); end
    bus_read(BASE + 14'd3, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL reset_level got %h want 0", rd); end
  endtask

  task automatic test_shot_pulse();
    logic [17:0] rd;
    int first = -1;
    int width = 0;
    logic other = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      tick();
      if (shot[0]) begin
        if (first < 0) first = t;
        width++;
      end
      other |= shot[1] | (|hit);
      if (t == 0)  trigger[0] = 1'b1;
      if (t == 20) trigger[0] = 1'b0;
    end
    checks++;
    if (first !== 7) begin errors++; $display("FAIL shot_start got %0d want 7", first); end
    checks++;
    if (width !== PW) begin errors++; $display("FAIL shot_width got %0d want %0d", width, PW); end
    checks++;
    if (other !== 1'b0) begin errors++; $display("FAIL shot_other_outputs got %b want 0", other); end
    bus_read(BASE, rd);
    checks++;
    if (rd !== 18'h1) begin errors++; $display("FAIL shot_evt_first got %h want 1", rd); end
    bus_read(BASE, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL shot_evt_cleared got %h want 0", rd); end
  endtask

  task automatic test_glitch();
    logic [17:0] rd;
    logic seen = 1'b0;
    for (int t = 0; t < 25; t++) begin
      tick();
      seen |= |hit;
      if (t == 0) sens[1] = 1'b1;
      if (t == 2) sens[1] = 1'b0;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch_hit_pulse got %b want 0", seen); end
    bus_read(BASE + 14'd1, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL glitch_hit_evt got %h want 0", rd); end
  endtask

  task automatic test_same_cycle();
    logic [17:0] rd;
    logic [17:0] rd_race = '0;
    // The event registers on edge 7; the read address is sampled on that same edge.
    for (int t = 0; t <= 8; t++) begin
      tick();
      if (t == 0) sens[0] = 1'b1;
      if (t == 6) begin addr = BASE + 14'd1; wr = 1'b0; end
      if (t == 7) begin rd_race = dout; addr = IDLE; end
    end
    checks++;
    if (rd_race !== 18'h0) begin errors++; $display("FAIL race_read got %h want 0", rd_race); end
    sens[0] = 1'b0;
    idle(20);
    bus_read(BASE + 14'd1, rd);
    checks++;
    if (rd !== 18'h1) begin errors++; $display("FAIL race_set_wins got %h want 1", rd); end
    bus_read(BASE + 14'd1, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL race_cleared got %h want 0", rd); end
  endtask

  task automatic test_disable_midpulse();
    logic [17:0] rd;
    logic late = 1'b0;
    for (int t = 0; t <= 9; t++) begin
      tick();
      if (t == 0) trigger[0] = 1'b1;
    end
    checks++;
    if (shot[0] !== 1'b1) begin errors++; $display("FAIL disable_pre_pulse got %b want 1", shot[0]); end
    bus_write(BASE + 14'd2, 18'h0);
    tick();
    checks++;
    if (shot[0] !== 1'b0) begin errors++; $display("FAIL disable_terminates got %b want 0", shot[0]); end
    trigger[0] = 1'b0;
    trigger[1] = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      late |= |shot;
      if (t == 10) trigger[1] = 1'b0;
    end
    checks++;
    if (late !== 1'b0) begin errors++; $display("FAIL disable_suppress got %b want 0", late); end
    bus_read(BASE, rd);
    checks++;
    if (rd !== 18'h1) begin errors++; $display("FAIL disable_flag_kept got %h want 1", rd); end
    bus_read(BASE + 14'd2, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL disable_enable_rd got %h want 0", rd); end
    bus_write(BASE + 14'd2, 18'h3);
    idle(10);
  endtask

  task automatic test_write_rules();
    logic [17:0] rd;
    trigger[0] = 1'b1;
    idle(8);
    trigger[0] = 1'b0;
    idle(20);
    bus_write(BASE, 18'h0);
    bus_write(BASE + 14'd1, 18'h3FFFF);
    bus_read(BASE, rd);
    checks++;
    if (rd !== 18'h1) begin errors++; $display("FAIL write_no_clear got %h want 1", rd); end
    bus_read(BASE + 14'd1, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL write_hit_ignored got %h want 0", rd); end
    bus_write(14'd10, 18'h0);
    bus_read(BASE + 14'd2, rd);
    checks++;
    if (rd !== 18'h3) begin errors++; $display("FAIL write_outside got %h want 3", rd); end
    bus_write(BASE + 14'd2, 18'h3FFFD);
    bus_read(BASE + 14'd2, rd);
    checks++;
    if (rd !== 18'h1) begin errors++; $display("FAIL write_enable_low got %h want 1", rd); end
    bus_write(BASE + 14'd2, 18'h3);
    trigger[1] = 1'b1;
    sens[0]    = 1'b1;
    idle(10);
    bus_read(BASE + 14'd3, rd);
    checks++;
    if (rd !== 18'h6) begin errors++; $display("FAIL level_live got %h want 6", rd); end
    bus_read(BASE - 14'd1, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL below_window got %h want 0", rd); end
    trigger = '0;
    sens    = '0;
    idle(20);
    bus_read(BASE, rd);
    bus_read(BASE + 14'd1, rd);
  endtask

  task automatic test_enable_mask();
    logic [17:0] rd;
    int cnt0 = 0;
    int cnt1 = 0;
    bus_write(BASE + 14'd2, 18'h2);
    for (int t = 0; t < 30; t++) begin
      tick();
      cnt0 += int'(shot[0]);
      cnt1 += int'(shot[1]);
      if (t == 0)  trigger = 2'b11;
      if (t == 10) trigger = 2'b00;
    end
    checks++;
    if (cnt0 !== 0) begin errors++; $display("FAIL mask_shot0 got %0d want 0", cnt0); end
    checks++;
    if (cnt1 !== PW) begin errors++; $display("FAIL mask_shot1 got %0d want %0d", cnt1, PW); end
    bus_read(BASE, rd);
    checks++;
    if (rd !== 18'h2) begin errors++; $display("FAIL mask_shot_evt got %h want 2", rd); end
  endtask

  task automatic test_reset_midpulse();
    logic [17:0] rd;
    logic seen = 1'b0;
    for (int t = 0; t <= 9; t++) begin
      tick();
      if (t == 0) trigger[1] = 1'b1;
    end
    checks++;
    if (shot[1] !== 1'b1) begin errors++; $display("FAIL rst_pre_pulse got %b want 1", shot[1]); end
    #2 CLR = 1'b0;
    #1;
    checks++;
    if ({shot, hit, dout} !== 22'h0) begin
      errors++; $display("FAIL rst_async_clear got %h want 0", {shot, hit, dout});
    end
    CLR = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      seen |= shot[1];
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_held_high_pulse got %b want 0", seen); end
    bus_read(BASE + 14'd2, rd);
    checks++;
    if (rd !== 18'h3) begin errors++; $display("FAIL rst_enable got %h want 3", rd); end
    bus_read(14'd10, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL rst_outside got %h want 0", rd); end
    bus_read(BASE, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL rst_held_high_flag got %h want 0", rd); end
    trigger[1] = 1'b0;
    idle(20);
    trigger[1] = 1'b1;
    idle(8);
    trigger[1] = 1'b0;
    idle(20);
    bus_read(BASE, rd);
    checks++;
    if (rd !== 18'h2) begin errors++; $display("FAIL rst_rearm got %h want 2", rd); end
  endtask

  // Model works on runs of equal raw input: a run differing from the accepted
  // level and at least DEB long flips the level; a 0->1 flip is an event whose
  // pulse begins DEB+3 cycles after the run starts unless one is still running.
  task automatic test_random();
    bit          raw_tab [4][RT];
    bit          exp_tab [4][RT];
    int          evts    [4];
    logic [17:0] rd;
    for (int r = 0; r < 3; r++) begin
      int shown = 0;
      idle(20);
      bus_read(BASE, rd);
      bus_read(BASE + 14'd1, rd);
      for (int c = 0; c < 4; c++) begin
        int t = 0;
        bit v = 1'b1;
        while (t < RLEN) begin
          int len = int'($urandom_range(1, 10));
          for (int k = 0; k < len && t < RLEN; k++) begin
            raw_tab[c][t] = v;
            t++;
          end
          v = ~v;
        end
        for (int k = RLEN; k < RT; k++) raw_tab[c][k] = 1'b0;
      end
      for (int c = 0; c < 4; c++) begin
        bit level = 1'b0;
        int last_end = -1;
        int s = 0;
        evts[c] = 0;
        for (int k = 0; k < RT; k++) exp_tab[c][k] = 1'b0;
        while (s < RT) begin
          int e = s;
          while (e < RT && raw_tab[c][e] == raw_tab[c][s]) e++;
          if (raw_tab[c][s] != level && (e - s) >= DEB) begin
            level = raw_tab[c][s];
            if (level) begin
              int ts = s + DEB + 3;
              evts[c]++;
              if (ts > last_end) begin
                for (int k = ts; k < ts + PW && k < RT; k++) exp_tab[c][k] = 1'b1;
                last_end = ts + PW - 1;
              end
            end
          end
          s = e;
        end
      end
      for (int t = 0; t < RT; t++) begin
        logic [3:0] want;
        tick();
        want = {exp_tab[3][t], exp_tab[2][t], exp_tab[1][t], exp_tab[0][t]};
        checks++;
        if ({hit, shot} !== want) begin
          errors++;
          if (shown < 8) $display("FAIL rand_pulses round %0d cycle %0d got %b want %b", r, t, {hit, shot}, want);
          shown++;
        end
        trigger = {raw_tab[1][t], raw_tab[0][t]};
        sens    = {raw_tab[3][t], raw_tab[2][t]};
      end
      bus_read(BASE, rd);
      checks++;
      if (rd !== {16'h0, evts[1] > 0, evts[0] > 0}) begin
        errors++; $display("FAIL rand_shot_evt round %0d got %h want %b", r, rd, {evts[1] > 0, evts[0] > 0});
      end
      bus_read(BASE + 14'd1, rd);
      checks++;
      if (rd !== {16'h0, evts[3] > 0, evts[2] > 0}) begin
        errors++; $display("FAIL rand_hit_evt round %0d got %h want %b", r, rd, {evts[3] > 0, evts[2] > 0});
      end
      bus_read(BASE + 14'd3, rd);
      checks++;
      if (rd !== 18'h0) begin errors++; $display("FAIL rand_level round %0d got %h want 0", r, rd); end
    end
  endtask

  task automatic test_hitcnt();
    logic [17:0] rd;
`ifdef PLAYER_IO_HIT_COUNT_EN
    bus_write(BASE + 14'd4, 18'h0);
    for (int e = 0; e < 300; e++) begin
      sens[0] = 1'b1;
      idle(5);
      sens[0] = 1'b0;
      idle(5);
      if (e == 99) begin
        idle(10);
        bus_read(BASE + 14'd4, rd);
        checks++;
        if (rd !== 18'd100) begin errors++; $display("FAIL hitcnt_100 got %0d want 100", rd); end
      end
    end
    idle(20);
    bus_read(BASE + 14'd4, rd);
    checks++;
    if (rd !== 18'd255) begin errors++; $display("FAIL hitcnt_saturate got %0d want 255", rd); end
    bus_write(BASE + 14'd4, 18'h0);
    bus_read(BASE + 14'd4, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL hitcnt_clear got %h want 0", rd); end
`else
    sens[0] = 1'b1;
    idle(8);
    sens[0] = 1'b0;
    idle(20);
    bus_read(BASE + 14'd4, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL hitcnt_absent0 got %h want 0", rd); end
    bus_read(BASE + 14'd5, rd);
    checks++;
    if (rd !== 18'h0) begin errors++; $display("FAIL hitcnt_absent1 got %h want 0", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_shot_pulse();
    test_glitch();
    test_same_cycle();
    test_disable_midpulse();
    test_write_rules();
    test_enable_mask();
    test_reset_midpulse();
    test_random();
    test_hitcnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_io_map.md
PLAYER_IO_MAP -- requirements
Module: player_io_map

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of player channels (1..8).
REQ-002 SHALL have parameter IO_BASE, default 14'd254, base address of the register window.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4, cycles an input must stay stable before it is accepted (1..255).
REQ-004 SHALL have parameter SHOT_PULSE_CYCLES, default 8, width of each shot/hit output pulse (1..255).
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port CLR, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port trigger, input, NUM_PLAYERS, raw asynchronous trigger buttons.
REQ-008 SHALL have port sens, input, NUM_PLAYERS, raw asynchronous hit sensors.
REQ-009 SHALL have port shot, output, NUM_PLAYERS, shot-fired pulses.
REQ-010 SHALL have port hit, output, NUM_PLAYERS, hit-taken pulses.
REQ-011 SHALL have bus ports wr (input, 1), addr (input, 14), din (input, 18) and dout (output, 18): the CPU data port.

Function
REQ-012 Each trigger and sens bit SHALL pass through a 2-flop synchroniser, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-013 A debounced rising edge SHALL count as an event; falling edges SHALL be ignored.
REQ-014 An accepted trigger event on an enabled channel SHALL drive shot[i] high for exactly SHOT_PULSE_CYCLES cycles and set sticky flag SHOT_EVT[i].
REQ-015 An accepted sens event on an enabled channel SHALL drive hit[i] high for exactly SHOT_PULSE_CYCLES cycles and set sticky flag HIT_EVT[i].
REQ-016 A new event arriving while that channel's pulse is active SHALL NOT retrigger or extend the pulse, but SHALL still set the sticky flag.
REQ-017 The register map SHALL be: IO_BASE+0 = SHOT_EVT (read-clear); IO_BASE+1 = HIT_EVT (read-clear); IO_BASE+2 = ENABLE mask (R/W); IO_BASE+3 = live debounced levels {sens, trigger} (read-only).
REQ-018 Each register SHALL place its data in the low bits; unused bits SHALL read 0.
REQ-019 Reads SHALL be registered: dout SHALL be valid 1 cycle after addr is presented.
REQ-020 For an address outside the window, dout SHALL be 0 and writes SHALL be ignored.
REQ-021 A read of a read-clear register SHALL clear the returned bits in the same cycle the address is sampled.
REQ-022 If an event and a read-clear hit the same bit in the same cycle, the set SHALL win: the bit reads 1 next time.
REQ-023 A write (wr=1) to IO_BASE+2 SHALL update ENABLE from din[NUM_PLAYERS-1:0]; writes to all other registers SHALL be ignored.
REQ-024 Disabling a channel SHALL terminate its active pulses on the next cycle and suppress new events; existing flags SHALL be kept.
REQ-025 A write cycle SHALL NOT perform a read-clear.

Reset
REQ-026 While CLR=0, the block SHALL asynchronously drive shot, hit, dout, SHOT_EVT, HIT_EVT, the synchronisers, the debounced levels and the counters to 0, and ENABLE to all-ones.
REQ-027 A reset asserted mid-pulse SHALL end the pulse immediately.
REQ-028 After release, an input held high SHALL NOT produce an event, because the debounced level restarts at 0 and sees a genuine rising edge only after a low period.

Configuration
REQ-029 With PLAYER_IO_HIT_COUNT_EN defined, each channel SHALL keep an 8-bit saturating hit counter, readable at IO_BASE+4+i and cleared by any write to that address.
REQ-030 Without PLAYER_IO_HIT_COUNT_EN, those counters SHALL be absent and those addresses SHALL be treated as outside the window (read 0).

Structure
REQ-031 Package player_io_pkg SHALL hold the register offset constants (OFS_SHOT_EVT=0, OFS_HIT_EVT=1, OFS_ENABLE=2, OFS_LEVEL=3, OFS_HITCNT=4) and the counter width constant.
REQ-032 Sub-module player_io_chan SHALL implement one input path (synchroniser, debouncer, edge detect, pulse timer) and SHALL be instantiated 2*NUM_PLAYERS times.

Verification
REQ-033 Scenario: NUM_PLAYERS=2, trigger[0] held high for 20 cycles -> shot[0] high for exactly 8 cycles, starting 2+4+1 cycles after the edge; read IO_BASE+0 returns 18'h1, then the next read returns 18'h0.
REQ-034 Scenario: a 2-cycle glitch on sens[1] with DEBOUNCE_CYCLES=4 -> no hit pulse and HIT_EVT=0.
REQ-035 Scenario: sens[0] event lands in the same cycle as a read of IO_BASE+1 -> that read returns 0 (or the prior value) and the next read returns 18'h1.
REQ-036 Scenario: write 18'h2 to IO_BASE+2, then pulse trigger[0] and trigger[1] -> only shot[1] pulses; SHOT_EVT reads 18'h2.
REQ-037 Scenario: CLR pulsed low during shot[1] at pulse cycle 3 -> shot goes to 0 at once; ENABLE reads 18'h3; addr 14'd10 reads 0.
REQ-038 Scenario: with PLAYER_IO_HIT_COUNT_EN, 300 sens[0] events -> IO_BASE+4 reads 255; a write to IO_BASE+4 makes it read 0.
